// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-back arbiter merging ALU results with a queued load stream.
// Writes to constant registers are dropped and flagged.
module reg_wb_ctrl #(
  parameter int PW = 3,
  parameter int PROT_BASE = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [PW-1:0]    alu_addr,
  input  logic [7:0]       alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [PW-1:0]    ld_addr,
  input  logic [7:0]       ld_data,
  output logic             wr_en,
  output logic [PW-1:0]    wr_addr,
  output logic [7:0]       dat_in,
  output logic [2**PW-1:0] pending,
  output logic             prot_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW:0] PB = (PW+1)'(PROT_BASE);
  logic [AW:0] wp, rp;
  logic [AW-1:0] wi, ri;
  logic [DEPTH-1:0] live;
  logic [PW-1:0] fa [DEPTH];
  logic [7:0] fd [DEPTH];
  logic full, empty, alu_ok, alu_bad, ld_hs, ld_bad, push, pop;
  always_comb begin
    wi = wp[AW-1:0];
    ri = rp[AW-1:0];
    empty = wp == rp;
    full = wi == ri && wp[AW] != rp[AW];
    alu_ok = alu_valid && {1'b0, alu_addr} < PB;
    alu_bad = alu_valid && !alu_ok;
    ld_hs = ld_valid && !full;
    ld_bad = ld_hs && {1'b0, ld_addr} >= PB;
    push = ld_hs && !ld_bad;
    pop = !alu_ok && !empty;
    ld_ready = !full;
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending[fa[i]] = 1'b1;
  end
  // Kill applies only to entries already queued; the push below wins for the
  // incoming slot, since a same-cycle load is younger than the ALU write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      live <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      dat_in <= '0;
      prot_err <= 1'b0;
    end else begin
      wr_en <= alu_ok || (pop && live[ri]);
      prot_err <= alu_bad || ld_bad;
      if (alu_ok) begin
        wr_addr <= alu_addr;
        dat_in <= alu_data;
      end else if (pop) begin
        wr_addr <= fa[ri];
        dat_in <= fd[ri];
      end
      for (int i = 0; i < DEPTH; i++)
        if (alu_ok && fa[i] == alu_addr) live[i] <= 1'b0;
      if (pop) begin
        live[ri] <= 1'b0;
        rp <= rp + 1'b1;
      end
      if (push) begin
        live[wi] <= 1'b1;
        wp <= wp + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      fa[wi] <= ld_addr;
      fd[wi] <= ld_data;
    end
endmodule
